// File: rtl/onchip_mem_arbiter_pkg.sv
// Shared definitions for the on-chip RAM arbiter.
// Holds the default geometry of the 25000 x 32-bit single-port RAM, the data
// word returned for out-of-range reads, and the grant encoding used between
// the round-robin core and the top-level datapath mux.
package onchip_mem_arb_pkg;

    localparam int          DEFAULT_ADDR_W   = 15;
    localparam int          DEFAULT_DATA_W   = 32;
    localparam int          DEFAULT_DEPTH    = 25000;
    localparam logic [31:0] DEFAULT_BAD_READ = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_A    = 2'd1,
        GNT_B    = 2'd2
    } grant_t;

    // Bit 0 of the one-hot grant is port A, bit 1 is port B.
    function automatic grant_t onehot_to_grant(input logic [1:0] gnt);
        grant_t g;
        case (gnt)
            2'b01:   g = GNT_A;
            2'b10:   g = GNT_B;
            default: g = GNT_NONE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// Avalon-MM pipelined port bundle (one per requester).
// master modport: the requester side (drives address/byteenable/read/write/
//                 writedata, receives waitrequest/readdata/readdatavalid).
// slave modport:  the arbiter side (the reverse).
interface onchip_mem_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/onchip_mem_arbiter_rr_arb2.sv
// rr_arb2: two-requester fair round-robin arbiter.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   req[1:0]      request vector (bit 0 = requester 0)
//   gnt[1:0]      one-hot grant, combinational from req and the last grant
// A lone requester is always granted; on a tie the requester that did not
// win last time is granted. After reset requester 1 counts as the last
// winner, so requester 0 wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_grant;   // 0 = requester 0 won last, 1 = requester 1 won last

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (|gnt) begin
            last_grant <= gnt[1];
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: shares one single-port on-chip RAM (1-cycle read
// latency) between two Avalon-MM pipelined masters with round-robin fairness.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   a, b              Avalon-MM slave ports (A = CPU data master, B = DMA)
//   mem_*             RAM address/byteenable/chipselect/write/writedata out,
//                     mem_readdata in (valid the cycle after the address)
//   err_clear         clears the sticky error flags
//   addr_err          sticky: some granted access was out of range
//   err_src           sticky: bit0 = A faulted, bit1 = B faulted
module onchip_mem_arbiter
    import onchip_mem_arb_pkg::*;
#(
    parameter int                ADDR_W   = DEFAULT_ADDR_W,
    parameter int                DATA_W   = DEFAULT_DATA_W,
    parameter int                DEPTH    = DEFAULT_DEPTH,
    parameter logic [DATA_W-1:0] BAD_READ = DEFAULT_BAD_READ
) (
    input  logic                clk,
    input  logic                reset_n,
    onchip_mem_arbiter_if.slave a,
    onchip_mem_arbiter_if.slave b,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    input  logic [DATA_W-1:0]   mem_readdata,
    input  logic                err_clear,
    output logic                addr_err,
    output logic [1:0]          err_src
);

    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

    // No grants until one full cycle after reset release.
    logic ready;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ready <= 1'b0;
        else          ready <= 1'b1;
    end

    logic [1:0] req;
    logic [1:0] gnt;
    grant_t     gnt_sel;

    assign req = {ready & (b.read | b.write), ready & (a.read | a.write)};

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .gnt     (gnt)
    );

    assign gnt_sel       = onehot_to_grant(gnt);
    assign a.waitrequest = ~gnt[0];
    assign b.waitrequest = ~gnt[1];

    // Granted-port mux
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W/8-1:0] sel_be;
    logic                sel_read;
    logic                sel_write;
    logic [DATA_W-1:0]   sel_wdata;

    always_comb begin
        sel_addr  = '0;
        sel_be    = '0;
        sel_read  = 1'b0;
        sel_write = 1'b0;
        sel_wdata = '0;
        case (gnt_sel)
            GNT_A: begin
                sel_addr  = a.address;
                sel_be    = a.byteenable;
                sel_read  = a.read;
                sel_write = a.write;
                sel_wdata = a.writedata;
            end
            GNT_B: begin
                sel_addr  = b.address;
                sel_be    = b.byteenable;
                sel_read  = b.read;
                sel_write = b.write;
                sel_wdata = b.writedata;
            end
            default: ;
        endcase
    end

    logic sel_valid;
    logic in_range;
    logic fault;
    logic rd_accept;

    assign sel_valid = (gnt_sel != GNT_NONE);
    assign in_range  = ({1'b0, sel_addr} < DEPTH_V);
    assign fault     = sel_valid & ~in_range;
    // Read and write together counts as a write.
    assign rd_accept = sel_valid & sel_read & ~sel_write;

    assign mem_address    = sel_addr;
    assign mem_byteenable = sel_be;
    assign mem_writedata  = sel_wdata;
    assign mem_chipselect = sel_valid & in_range;
    assign mem_write      = sel_valid & in_range & sel_write;

    // Read return pipeline: which port is owed data, and whether it is real.
    logic rd_vld;
    logic rd_port;      // 0 = A, 1 = B
    logic rd_in_range;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld      <= 1'b0;
            rd_port     <= 1'b0;
            rd_in_range <= 1'b0;
        end else begin
            rd_vld      <= rd_accept;
            rd_port     <= (gnt_sel == GNT_B);
            rd_in_range <= in_range;
        end
    end

    logic [DATA_W-1:0] rd_data;
    assign rd_data = rd_in_range ? mem_readdata : BAD_READ;

    assign a.readdatavalid = rd_vld & ~rd_port;
    assign b.readdatavalid = rd_vld &  rd_port;
    assign a.readdata      = a.readdatavalid ? rd_data : '0;
    assign b.readdata      = b.readdatavalid ? rd_data : '0;

    // Sticky error flags: clear first, then a simultaneous new fault sets.
    logic [1:0] fault_src;
    assign fault_src = {fault & (gnt_sel == GNT_B), fault & (gnt_sel == GNT_A)};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_err <= 1'b0;
            err_src  <= 2'b00;
        end else begin
            addr_err <= (addr_err & ~err_clear) | fault;
            err_src  <= (err_src & {2{~err_clear}}) | fault_src;
        end
    end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
module tb_onchip_mem_arbiter;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 25000;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic [31:0]       mem_readdata;
    logic              err_clear;
    logic              addr_err;
    logic [1:0]        err_src;

    int n_chk  = 0;
    int n_pass = 0;

    onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) a_if ();
    onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b_if ();

    onchip_mem_arbiter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .a              (a_if),
        .b              (b_if),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (mem_readdata),
        .err_clear      (err_clear),
        .addr_err       (addr_err),
        .err_src        (err_src)
    );

    always #5 clk = ~clk;

    // RAM model: word i initialised to {16'hA5A5, i}; 1-cycle read latency.
    logic [31:0] ram [0:DEPTH-1];
    logic [31:0] ram_q = 32'h0;
    assign mem_readdata = ram_q;

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = {16'hA5A5, 16'(i)};
    end

    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int k = 0; k < 4; k++)
                    if (mem_byteenable[k]) ram[mem_address][8*k +: 8] <= mem_writedata[8*k +: 8];
            end else begin
                ram_q <= ram[mem_address];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ports();
        a_if.read = 1'b0; a_if.write = 1'b0; a_if.address = '0;
        a_if.byteenable = 4'hF; a_if.writedata = '0;
        b_if.read = 1'b0; b_if.write = 1'b0; b_if.address = '0;
        b_if.byteenable = 4'hF; b_if.writedata = '0;
    endtask

    initial begin
        reset_n   = 1'b0;
        err_clear = 1'b0;
        idle_ports();
        tick(); tick();

        // Reset state
        @(negedge clk);
        chk("rst_a_wait", 32'(a_if.waitrequest), 32'd1);
        chk("rst_b_wait", 32'(b_if.waitrequest), 32'd1);
        chk("rst_a_rdv", 32'(a_if.readdatavalid), 32'd0);
        chk("rst_b_rdv", 32'(b_if.readdatavalid), 32'd0);
        chk("rst_a_rdata", a_if.readdata, 32'd0);
        chk("rst_b_rdata", b_if.readdata, 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        chk("rst_err_src", 32'(err_src), 32'd0);

        // Release reset with A reading word 0: held off one cycle, then accepted
        tick();
        reset_n = 1'b1;
        a_if.read = 1'b1; a_if.address = 15'h0000;
        @(negedge clk);
        chk("c1_a_wait", 32'(a_if.waitrequest), 32'd1);
        chk("c1_cs", 32'(mem_chipselect), 32'd0);
        tick();
        @(negedge clk);
        chk("c2_a_wait", 32'(a_if.waitrequest), 32'd0);
        chk("c2_cs", 32'(mem_chipselect), 32'd1);
        chk("c2_addr", 32'(mem_address), 32'd0);
        tick();
        a_if.read = 1'b0;
        @(negedge clk);
        chk("c3_a_rdv", 32'(a_if.readdatavalid), 32'd1);
        chk("c3_a_rdata", a_if.readdata, 32'hA5A5_0000);
        chk("c3_b_rdv", 32'(b_if.readdatavalid), 32'd0);

        // Both read continuously; A won last, so B goes first
        tick();
        a_if.read = 1'b1; a_if.address = 15'd1;
        b_if.read = 1'b1; b_if.address = 15'd2;
        @(negedge clk);
        chk("rr0_b_wait", 32'(b_if.waitrequest), 32'd0);
        chk("rr0_a_wait", 32'(a_if.waitrequest), 32'd1);
        chk("rr0_addr", 32'(mem_address), 32'd2);
        tick();
        b_if.address = 15'd4;
        @(negedge clk);
        chk("rr1_a_wait", 32'(a_if.waitrequest), 32'd0);
        chk("rr1_b_wait", 32'(b_if.waitrequest), 32'd1);
        chk("rr1_b_rdv", 32'(b_if.readdatavalid), 32'd1);
        chk("rr1_b_rdata", b_if.readdata, 32'hA5A5_0002);
        chk("rr1_a_rdv", 32'(a_if.readdatavalid), 32'd0);
        tick();
        a_if.address = 15'd3;
        @(negedge clk);
        chk("rr2_b_wait", 32'(b_if.waitrequest), 32'd0);
        chk("rr2_a_rdv", 32'(a_if.readdatavalid), 32'd1);
        chk("rr2_a_rdata", a_if.readdata, 32'hA5A5_0001);
        tick();
        b_if.read = 1'b0;
        @(negedge clk);
        chk("rr3_a_wait", 32'(a_if.waitrequest), 32'd0);
        chk("rr3_b_rdata", b_if.readdata, 32'hA5A5_0004);
        tick();
        a_if.read = 1'b0;
        @(negedge clk);
        chk("rr4_a_rdata", a_if.readdata, 32'hA5A5_0003);
        chk("rr4_b_rdv", 32'(b_if.readdatavalid), 32'd0);

        // Partial write by A then B reads the same word next cycle
        tick();
        a_if.write = 1'b1; a_if.address = 15'h0010;
        a_if.writedata = 32'h1234_5678; a_if.byteenable = 4'b0011;
        @(negedge clk);
        chk("wr_a_wait", 32'(a_if.waitrequest), 32'd0);
        chk("wr_mem_write", 32'(mem_write), 32'd1);
        chk("wr_be", 32'(mem_byteenable), 32'h3);
        tick();
        a_if.write = 1'b0; a_if.byteenable = 4'hF;
        b_if.read = 1'b1; b_if.address = 15'h0010;
        @(negedge clk);
        chk("rw_b_wait", 32'(b_if.waitrequest), 32'd0);
        tick();
        b_if.read = 1'b0;
        @(negedge clk);
        chk("rw_b_rdata", b_if.readdata, 32'hA5A5_5678);

        // B writes out of range, then reads out of range
        tick();
        b_if.write = 1'b1; b_if.address = 15'd25000; b_if.writedata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("oor_wr_cs", 32'(mem_chipselect), 32'd0);
        chk("oor_wr_wait", 32'(b_if.waitrequest), 32'd0);
        tick();
        b_if.write = 1'b0;
        b_if.read = 1'b1; b_if.address = 15'd25001;
        @(negedge clk);
        chk("oor_addr_err", 32'(addr_err), 32'd1);
        chk("oor_err_src", 32'(err_src), 32'h2);
        chk("oor_rd_cs", 32'(mem_chipselect), 32'd0);
        tick();
        b_if.read = 1'b0;
        @(negedge clk);
        chk("oor_rdv", 32'(b_if.readdatavalid), 32'd1);
        chk("oor_rdata", b_if.readdata, 32'hDEAD_BEEF);

        // err_clear together with a new A fault: set wins
        tick();
        a_if.read = 1'b1; a_if.address = 15'h7FFF;
        err_clear = 1'b1;
        tick();
        a_if.read = 1'b0;
        err_clear = 1'b0;
        @(negedge clk);
        chk("clr_addr_err", 32'(addr_err), 32'd1);
        chk("clr_err_src", 32'(err_src), 32'h1);
        chk("clr_a_rdata", a_if.readdata, 32'hDEAD_BEEF);
        tick();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        @(negedge clk);
        chk("clr2_addr_err", 32'(addr_err), 32'd0);
        chk("clr2_err_src", 32'(err_src), 32'h0);

        // Reset asserted right after a read is accepted
        tick();
        a_if.read = 1'b1; a_if.address = 15'd5;
        @(negedge clk);
        chk("mr_a_wait", 32'(a_if.waitrequest), 32'd0);
        tick();
        a_if.read = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("mr_a_rdv", 32'(a_if.readdatavalid), 32'd0);
        chk("mr_a_rdata", a_if.readdata, 32'd0);
        chk("mr_a_wait_rst", 32'(a_if.waitrequest), 32'd1);
        @(negedge clk);
        chk("mr_b_wait_rst", 32'(b_if.waitrequest), 32'd1);
        tick();
        chk("mr_a_rdv_later", 32'(a_if.readdatavalid), 32'd0);

        // Release with both pending: A wins the first tie
        reset_n = 1'b1;
        a_if.read = 1'b1; a_if.address = 15'd6;
        b_if.read = 1'b1; b_if.address = 15'd7;
        @(negedge clk);
        chk("tie0_a_wait", 32'(a_if.waitrequest), 32'd1);
        chk("tie0_b_wait", 32'(b_if.waitrequest), 32'd1);
        tick();
        @(negedge clk);
        chk("tie1_a_wait", 32'(a_if.waitrequest), 32'd0);
        chk("tie1_b_wait", 32'(b_if.waitrequest), 32'd1);
        tick();
        a_if.read = 1'b0;
        @(negedge clk);
        chk("tie2_b_wait", 32'(b_if.waitrequest), 32'd0);
        chk("tie2_a_rdata", a_if.readdata, 32'hA5A5_0006);
        tick();
        b_if.read = 1'b0;
        @(negedge clk);
        chk("tie3_b_rdata", b_if.readdata, 32'hA5A5_0007);
        chk("tie3_a_rdv", 32'(a_if.readdatavalid), 32'd0);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
